// File: rtl/axil_regbank_pkg.sv
// Shared AXI4-Lite response codes and address decode helper for the register bank.
// Combinational helpers only; no latency and no backpressure of their own.
package axil_regbank_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_regbank_wr.sv
// Write-side AW/W join with holding registers and B channel; commit strobe is combinational on the completing edge.
// Latency 1 (BVALID rises on commit edge); AW/W readies drop while their holder is full or BVALID waits on BREADY.
module axil_regbank_wr
  import axil_regbank_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 6,
  localparam int LSB        = addr_lsb(DATA_WIDTH),
  localparam int IDX_W      = ADDR_WIDTH - LSB,
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_W-1:0]     i_wstrb,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic                  o_commit,
  output logic [IDX_W-1:0]      o_idx,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [STRB_W-1:0]     o_strb,
  input  logic                  i_err
);

  logic                  r_aw_held;
  logic                  r_w_held;
  logic                  r_bvalid;
  logic [IDX_W-1:0]      r_awidx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  resp_t                 r_bresp;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_unused;

  assign o_awready = !i_rst && !r_aw_held && !r_bvalid;
  assign o_wready  = !i_rst && !r_w_held && !r_bvalid;
  assign w_aw_hs   = i_awvalid && o_awready;
  assign w_w_hs    = i_wvalid && o_wready;

  // Whichever half arrives on the completing edge bypasses its holder.
  assign o_idx    = w_aw_hs ? i_awaddr[ADDR_WIDTH-1:LSB] : r_awidx;
  assign o_data   = w_w_hs ? i_wdata : r_wdata;
  assign o_strb   = w_w_hs ? i_wstrb : r_wstrb;
  assign o_commit = (w_aw_hs || r_aw_held) && (w_w_hs || r_w_held);

  assign o_bvalid = r_bvalid;
  assign o_bresp  = r_bresp;
  assign w_unused = ^i_awaddr[LSB-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awidx   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (o_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= i_err ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awidx   <= i_awaddr[ADDR_WIDTH-1:LSB];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= i_wdata;
        r_wstrb  <= i_wstrb;
      end
      if (r_bvalid && i_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axil_regbank.sv
// Parametrised AXI4-Lite register bank with byte strobes, SLVERR decode and per-register access pulses.
// Write and read each complete 1 cycle after handshake; one outstanding per channel, readies held low until B/R drain.
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int                DATA_WIDTH = 32,
  parameter int                ADDR_WIDTH = 6,
  parameter int                NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o,
  output logic [NUM_REGS-1:0]            rd_pulse_o
);

  localparam int LSB    = addr_lsb(DATA_WIDTH);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;
  logic [NUM_REGS-1:0]   r_rd_pulse;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  resp_t                 r_rresp;

  logic                  w_commit;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_ar_hs;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [STRB_W-1:0]     w_wr_strb;
  logic [NUM_REGS-1:0]   w_wr_sel;
  logic [NUM_REGS-1:0]   w_rd_sel;
  logic                  w_unused;

  axil_regbank_wr #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr (
    .i_clk     (ACLK),
    .i_rst     (ARESET),
    .i_awaddr  (S_AXI_AWADDR),
    .i_awvalid (S_AXI_AWVALID),
    .o_awready (S_AXI_AWREADY),
    .i_wdata   (S_AXI_WDATA),
    .i_wstrb   (S_AXI_WSTRB),
    .i_wvalid  (S_AXI_WVALID),
    .o_wready  (S_AXI_WREADY),
    .o_bresp   (S_AXI_BRESP),
    .o_bvalid  (S_AXI_BVALID),
    .i_bready  (S_AXI_BREADY),
    .o_commit  (w_commit),
    .o_idx     (w_wr_idx),
    .o_data    (w_wr_data),
    .o_strb    (w_wr_strb),
    .i_err     (!w_wr_ok)
  );

  assign w_rd_idx = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
  assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[LSB-1:0]};

  // Out-of-range indices match no register, leaving ok=0 and read word=0.
  always_comb begin
    w_wr_sel  = '0;
    w_rd_sel  = '0;
    w_wr_ok   = 1'b0;
    w_rd_ok   = 1'b0;
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_wr_idx == IDX_W'(i)) begin
        w_wr_sel[i] = 1'b1;
        w_wr_ok     = !RO_MASK[i];
      end
      if (w_rd_idx == IDX_W'(i)) begin
        w_rd_sel[i] = 1'b1;
        w_rd_ok     = 1'b1;
        w_rd_word   = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit && w_wr_ok) begin
        r_wr_pulse <= w_wr_sel;
        for (int i = 0; i < NUM_REGS; i++) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_wr_sel[i] && w_wr_strb[b]) r_regs[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read samples r_regs before this edge's write lands, so a colliding read sees the old value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rd_pulse <= '0;
    end else begin
      r_rd_pulse <= '0;
      if (w_ar_hs) begin
        r_rvalid   <= 1'b1;
        r_rdata    <= w_rd_word;
        r_rresp    <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
        r_rd_pulse <= w_rd_sel;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_ctrl
      assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end
  endgenerate

  assign S_AXI_ARREADY = !ARESET && !r_rvalid;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign wr_pulse_o    = r_wr_pulse;
  assign rd_pulse_o    = r_rd_pulse;

endmodule

// File: tb/tb_axil_regbank.sv
// Directed bench for axil_regbank: vector table for single transactions, hand sequences for timing corners.
module tb_axil_regbank;
  import axil_regbank_pkg::*;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [5:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [5:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [255:0] ctrl_o;
  logic [255:0] status_i;
  logic [7:0]   wr_pulse_o;
  logic [7:0]   rd_pulse_o;

  always #5 ACLK = ~ACLK;

  // Register 7 is read-only so the RO path is exercised by the same instance.
  axil_regbank #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (6),
    .NUM_REGS   (8),
    .RO_MASK    (8'h80)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .ctrl_o        (ctrl_o),
    .status_i      (status_i),
    .wr_pulse_o    (wr_pulse_o),
    .rd_pulse_o    (rd_pulse_o)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         wr;
    logic [5:0] addr;
    logic [31:0] data;   // write data, or expected RDATA for reads
    logic [3:0] strb;
    logic [1:0] resp;
    logic [7:0] pulse;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit wr, logic [5:0] a, logic [31:0] d, logic [3:0] s,
                              logic [1:0] r, logic [7:0] p);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.pulse = p;
    return v;
  endfunction

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [7:0] pulse, output bit tmo);
    logic aw_go, w_go;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    tmo = 1'b1; resp = 2'b11; pulse = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
      w_go  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_go) S_AXI_AWVALID = 1'b0;
      if (w_go)  S_AXI_WVALID  = 1'b0;
      if (S_AXI_BVALID) begin
        resp = S_AXI_BRESP; pulse = wr_pulse_o; tmo = 1'b0;
        break;
      end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, output logic [31:0] data, output logic [1:0] resp,
                         output logic [7:0] pulse, output bit tmo);
    logic go;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    tmo = 1'b1; data = '0; resp = 2'b11; pulse = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      go = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (go) S_AXI_ARVALID = 1'b0;
      if (S_AXI_RVALID) begin
        data = S_AXI_RDATA; resp = S_AXI_RRESP; pulse = rd_pulse_o; tmo = 1'b0;
        break;
      end
    end
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
    $fatal(1);
  end

  initial begin
    logic [1:0]   resp;
    logic [7:0]   pulse;
    logic [31:0]  rdata;
    logic [255:0] exp_ctrl;
    bit           tmo;
    int           bv_cnt, pl_cnt, rdy_seen;

    for (int i = 0; i < 8; i++) status_i[i*32 +: 32] = 32'h1111_0000 + 32'(i);
    status_i[7*32 +: 32] = 32'hDEAD_BEEF;

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

    // Vector table: basic fill/readback, RO lane, decode errors, byte strobes.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 6'(i*4), 32'(i+1), 4'hF, (i == 7) ? RESP_SLVERR : RESP_OKAY,
                       (i == 7) ? 8'h00 : 8'(1 << i)));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0, 6'(i*4), 32'(i+1), 4'h0, RESP_OKAY, 8'(1 << i)));
    tbl.push_back(mk(0, 6'h1C, 32'hDEAD_BEEF, 4'h0, RESP_OKAY,   8'h80));
    tbl.push_back(mk(0, 6'h0E, 32'h0000_0004, 4'h0, RESP_OKAY,   8'h08));
    tbl.push_back(mk(0, 6'h20, 32'h0000_0000, 4'h0, RESP_SLVERR, 8'h00));
    tbl.push_back(mk(1, 6'h20, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 8'h00));
    tbl.push_back(mk(1, 6'h1C, 32'h1234_5678, 4'hF, RESP_SLVERR, 8'h00));
    tbl.push_back(mk(1, 6'h08, 32'hAABB_CCDD, 4'h2, RESP_OKAY,   8'h04));
    tbl.push_back(mk(0, 6'h08, 32'h0000_CC03, 4'h0, RESP_OKAY,   8'h04));
    tbl.push_back(mk(1, 6'h04, 32'hFFFF_FFFF, 4'h0, RESP_OKAY,   8'h02));
    tbl.push_back(mk(0, 6'h04, 32'h0000_0002, 4'h0, RESP_OKAY,   8'h02));
    tbl.push_back(mk(0, 6'h3C, 32'h0000_0000, 4'h0, RESP_SLVERR, 8'h00));

    repeat (3) @(posedge ACLK);
    #1;
    check("rst_bvalid",  S_AXI_BVALID, 1'b0);
    check("rst_rvalid",  S_AXI_RVALID, 1'b0);
    check("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    check("rst_resp",    {S_AXI_BRESP, S_AXI_RRESP}, 4'h0);
    check("rst_rdata",   S_AXI_RDATA, 32'h0);
    check("rst_ctrl",    ctrl_o, 256'h0);
    check("rst_pulses",  {wr_pulse_o, rd_pulse_o}, 16'h0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("idle_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    foreach (tbl[k]) begin
      if (tbl[k].wr) begin
        do_write(tbl[k].addr, tbl[k].data, tbl[k].strb, resp, pulse, tmo);
        check($sformatf("v%0d_wr_timeout", k), tmo, 1'b0);
        check($sformatf("v%0d_bresp", k), resp, tbl[k].resp);
        check($sformatf("v%0d_wr_pulse", k), pulse, tbl[k].pulse);
      end else begin
        do_read(tbl[k].addr, rdata, resp, pulse, tmo);
        check($sformatf("v%0d_rd_timeout", k), tmo, 1'b0);
        check($sformatf("v%0d_rdata", k), rdata, tbl[k].data);
        check($sformatf("v%0d_rresp", k), resp, tbl[k].resp);
        check($sformatf("v%0d_rd_pulse", k), pulse, tbl[k].pulse);
      end
      check($sformatf("v%0d_pulse_gone", k), {wr_pulse_o, rd_pulse_o}, 16'h0);
    end

    check("ctrl_lane3", ctrl_o[3*32 +: 32], 32'h4);
    exp_ctrl = {32'h0, 32'h7, 32'h6, 32'h5, 32'h4, 32'h0000_CC03, 32'h2, 32'h1};
    check("ctrl_all", ctrl_o, exp_ctrl);

    // W leads AW by 3 cycles; BREADY held off for 5 BVALID cycles.
    S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    check("t3_wready_free", S_AXI_WREADY, 1'b1);
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    check("t3_w_held_readies", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b10);
    check("t3_no_early_b", S_AXI_BVALID, 1'b0);
    repeat (2) @(posedge ACLK);
    #1;
    S_AXI_AWADDR = 6'h10; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    bv_cnt = 0; pl_cnt = 0; rdy_seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        check("t3_bresp", S_AXI_BRESP, RESP_OKAY);
        check("t3_pulse", wr_pulse_o, 8'h10);
      end
      bv_cnt += int'(S_AXI_BVALID);
      pl_cnt += int'(wr_pulse_o != 8'h0);
      rdy_seen += int'(S_AXI_AWREADY || S_AXI_WREADY);
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    check("t3_bvalid_cycles", bv_cnt, 5);
    check("t3_pulse_cycles", pl_cnt, 1);
    check("t3_readies_while_b", rdy_seen, 0);
    check("t3_bvalid_dropped", S_AXI_BVALID, 1'b0);
    check("t3_readies_back", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    do_read(6'h10, rdata, resp, pulse, tmo);
    check("t3_readback", rdata, 32'h1234_5678);

    // Read and write to register 5 commit on the same edge: read sees old value.
    S_AXI_AWADDR = 6'h14; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 6'h14; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check("coll_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    check("coll_rdata_old", S_AXI_RDATA, 32'h6);
    check("coll_ctrl_new", ctrl_o[5*32 +: 32], 32'h99);
    check("coll_pulses", {wr_pulse_o, rd_pulse_o}, 16'h2020);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;

    // Reset while B and R are both pending.
    S_AXI_AWADDR = 6'h00; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check("t6_pending", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    check("t6_reg0", ctrl_o[31:0], 32'h5);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check("t6_valids_cleared", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    check("t6_ctrl_cleared", ctrl_o, 256'h0);
    check("t6_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    do_read(6'h00, rdata, resp, pulse, tmo);
    check("t6_rd_timeout", tmo, 1'b0);
    check("t6_reg0_after", rdata, 32'h0);
    check("t6_rresp_after", resp, RESP_OKAY);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
